fmul_arbiter: RTL and testbench
===============================

FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one pipelined FP multiplier, range 2..8.
REQ-002 SHALL have parameter TAG_DEPTH, default 8: in-flight operation capacity, a power of two, at least the multiplier latency plus 1.
REQ-003 SHALL have port clk, input, 1: clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_vld, input, N_REQ: per-requester operation valid.
REQ-006 SHALL have port req_a, input, N_REQ x FLEN: per-requester operand a.
REQ-007 SHALL have port req_b, input, N_REQ x FLEN: per-requester operand b.
REQ-008 SHALL have port req_rdy, output, N_REQ: one-hot-or-zero grant; a transfer occurs when req_vld[i] and req_rdy[i] are both high.
REQ-009 SHALL have port mul_arg_vld, output, 1: issue strobe to the multiplier.
REQ-010 SHALL have port mul_a, output, FLEN: multiplier operand a.
REQ-011 SHALL have port mul_b, output, FLEN: multiplier operand b.
REQ-012 SHALL have port mul_res_vld, input, 1: multiplier result strobe; results return in order at a fixed latency.
REQ-013 SHALL have ports mul_res, input, FLEN, and mul_err, input, 1: multiplier result and error flag.
REQ-014 SHALL have port res_vld, output, N_REQ: one-hot result strobe routed to the originating requester.
REQ-015 SHALL have ports res, output, FLEN, and res_err, output, 1: result and error, shared by all requesters.
REQ-016 SHALL have port busy, output, 1: high when the tag FIFO is non-empty or mul_arg_vld is high.
REQ-017 SHALL have port proto_err, output, 1: sticky flag for a result received with no tag in flight.

Function
REQ-018 SHALL grant combinationally in round-robin order: starting at index ptr, pick the first i with req_vld[i], wrapping at N_REQ.
REQ-019 SHALL set ptr to (granted index + 1) mod N_REQ only on a transfer; ptr SHALL hold when no transfer occurs.
REQ-020 SHALL drive all req_rdy low when the tag FIFO holds TAG_DEPTH entries (full), counting the operation being issued this cycle.
REQ-021 SHALL register an accepted transfer: mul_arg_vld, mul_a and mul_b valid exactly 1 cycle after acceptance; at most 1 issue per cycle.
REQ-022 SHALL push the granted index as a tag into the tag FIFO on acceptance.
REQ-023 SHALL, on mul_res_vld, pop the FIFO head tag and in the same cycle drive res_vld[tag]=1, res=mul_res, res_err=mul_err (0 cycles).
REQ-024 SHALL handle a simultaneous push and pop in one cycle with the occupancy unchanged; a pop on full SHALL free one slot on the next cycle.
REQ-025 SHALL, on mul_res_vld with the FIFO empty, assert no res_vld and set proto_err until reset.
REQ-026 SHALL give every continuously requesting requester a grant within N_REQ transfers.

Reset
REQ-027 SHALL, while rst is high, force ptr=0, an empty FIFO, and mul_arg_vld=0, res_vld=0, req_rdy=0, proto_err=0, busy=0; mul_a and mul_b SHALL be 0.
REQ-028 SHALL discard in-flight tags on reset mid-operation; the multiplier shares rst, so no stale results follow.

Configuration
REQ-029 SHALL, with macro FMUL_ARBITER_STATS_EN defined, provide output grant_cnt (N_REQ x 32, wrapping, cleared by rst) incremented per transfer, plus output max_occupancy (highest FIFO level since reset).
REQ-030 SHALL, without FMUL_ARBITER_STATS_EN, omit these ports and their logic; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL take FLEN and NE from the shared FP package; the tag typedef SHALL be logic[$clog2(N_REQ)-1:0] in the same package.
REQ-032 SHALL put the tag FIFO in sub-module fmul_arbiter_tag_fifo (push, pop, full, empty, head, level).

Verification
REQ-033 SHALL verify: req_vld=0001, a=2.0, b=3.0 with a 3-cycle multiplier -> mul_arg_vld at +1 cycle, res_vld=0001, res=6.0 at +4 cycles.
REQ-034 SHALL verify: req_vld=1111 held for 8 cycles -> grants in order 0,1,2,3,0,1,2,3 and results routed in the same order.
REQ-035 SHALL verify: TAG_DEPTH=4 with results delayed to stay in flight -> req_rdy=0000 after 4 issues, resuming in the cycle after the first pop.
REQ-036 SHALL verify: mul_res_vld pulsed with an empty FIFO -> res_vld=0000, proto_err=1 until rst.
REQ-037 SHALL verify: rst asserted with 3 operations in flight -> busy=0 and ptr=0 next cycle; a following request from requester 2 gets its grant immediately.
REQ-038 SHALL verify: with FMUL_ARBITER_STATS_EN, 10 transfers from requester 1 -> grant_cnt[1]=10.

Source files
------------

// File: rtl/fmul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fmul_arbiter_pkg
// Description : Shared FP widths, tag type and helpers for fmul_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fmul_arbiter_pkg;

    localparam int FLEN      = 32;
    localparam int NE        = 8;
    localparam int N_REQ_MAX = 8;

    // Tag wide enough for the largest supported requester count.
    typedef logic [$clog2(N_REQ_MAX)-1:0] tag_t;

    localparam int TAG_W = $bits(tag_t);

    function automatic logic [N_REQ_MAX-1:0] tag_onehot(input tag_t t);
        return N_REQ_MAX'(1) << t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmul_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fmul_arbiter_tag_fifo
// Description : Power-of-two FIFO holding requester tags of in-flight ops.
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_arbiter_tag_fifo
    import fmul_arbiter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  tag_t                     din,
    output logic                     full,
    output logic                     empty,
    output tag_t                     head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    tag_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_level == LW'(DEPTH));
    assign empty  = (r_level == '0);
    assign head   = r_mem[r_rd];
    assign level  = r_level;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fmul_arbiter
// Description : Round-robin arbiter sharing one pipelined FP multiplier;
//               results are routed back by tag. Optional statistics ports
//               enabled by macro FMUL_ARBITER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_arbiter
    import fmul_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_vld,
    input  logic [N_REQ*FLEN-1:0]         req_a,
    input  logic [N_REQ*FLEN-1:0]         req_b,
    output logic [N_REQ-1:0]              req_rdy,
    output logic                          mul_arg_vld,
    output logic [FLEN-1:0]               mul_a,
    output logic [FLEN-1:0]               mul_b,
    input  logic                          mul_res_vld,
    input  logic [FLEN-1:0]               mul_res,
    input  logic                          mul_err,
    output logic [N_REQ-1:0]              res_vld,
    output logic [FLEN-1:0]               res,
    output logic                          res_err,
    output logic                          busy,
`ifdef FMUL_ARBITER_STATS_EN
    output logic [N_REQ*32-1:0]           grant_cnt,
    output logic [$clog2(TAG_DEPTH):0]    max_occupancy,
`endif
    output logic                          proto_err
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int LVL_W = $clog2(TAG_DEPTH) + 1;

    logic [PTR_W-1:0]      r_ptr;
    logic                  r_mul_vld;
    logic [FLEN-1:0]       r_mul_a;
    logic [FLEN-1:0]       r_mul_b;
    logic                  r_proto_err;

    logic [N_REQ-1:0]      w_mask;
    logic [N_REQ-1:0]      w_hi;
    logic [N_REQ-1:0]      w_pick;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [FLEN-1:0]       w_op_a;
    logic [FLEN-1:0]       w_op_b;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    tag_t                  w_head;
    logic [N_REQ_MAX-1:0]  w_head_oh;
    logic [LVL_W-1:0]      w_level;

    // Requests at or above ptr win first; otherwise wrap to the lowest index.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_mask[i] = (PTR_W'(i) >= r_ptr);
        end
    end

    assign w_hi   = req_vld & w_mask;
    assign w_pick = (|w_hi) ? w_hi : req_vld;

    always_comb begin
        w_gnt_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_pick[i]) w_gnt_idx = PTR_W'(i);
        end
    end

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_idx == PTR_W'(i)) begin
                w_op_a = req_a[i*FLEN +: FLEN];
                w_op_b = req_b[i*FLEN +: FLEN];
            end
        end
    end

    assign w_accept  = !rst && (|req_vld) && !w_full;
    assign w_ptr_nxt = (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_rdy[i] = w_accept && (w_gnt_idx == PTR_W'(i));
        end
    end

    fmul_arbiter_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (tag_t'(w_gnt_idx)),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head),
        .level (w_level)
    );

    // Results return in issue order, so the FIFO head names the owner.
    assign w_pop     = !rst && mul_res_vld && !w_empty;
    assign w_head_oh = tag_onehot(w_head);
    assign res_vld   = w_pop ? w_head_oh[N_REQ-1:0] : '0;
    assign res       = mul_res;
    assign res_err   = mul_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_mul_vld   <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_mul_vld <= w_accept;
            if (w_accept) begin
                r_ptr   <= w_ptr_nxt;
                r_mul_a <= w_op_a;
                r_mul_b <= w_op_b;
            end
            if (mul_res_vld && w_empty) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign mul_arg_vld = r_mul_vld;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign proto_err   = r_proto_err;
    assign busy        = !rst && ((w_level != '0) || r_mul_vld);

`ifdef FMUL_ARBITER_STATS_EN
    logic [N_REQ*32-1:0] r_grant_cnt;
    logic [LVL_W-1:0]    r_max_occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cnt <= '0;
            r_max_occ   <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept && (w_gnt_idx == PTR_W'(i))) begin
                    r_grant_cnt[i*32 +: 32] <= r_grant_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if (w_level > r_max_occ) begin
                r_max_occ <= w_level;
            end
        end
    end

    assign grant_cnt     = r_grant_cnt;
    assign max_occupancy = r_max_occ;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmul_arbiter
// Description : Self-checking bench for fmul_arbiter with a 3-cycle FP
//               multiplier model; stats checks need FMUL_ARBITER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_arbiter;
    import fmul_arbiter_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT, TAG_DEPTH 8, fed by the multiplier model
    logic [N-1:0]      req_vld;
    logic [N*FLEN-1:0] req_a;
    logic [N*FLEN-1:0] req_b;
    logic [N-1:0]      req_rdy;
    logic              mul_arg_vld;
    logic [FLEN-1:0]   mul_a;
    logic [FLEN-1:0]   mul_b;
    logic              mul_res_vld;
    logic [FLEN-1:0]   mul_res;
    logic              mul_err;
    logic [N-1:0]      res_vld;
    logic [FLEN-1:0]   res;
    logic              res_err;
    logic              busy;
    logic              proto_err;
    logic              inj_vld;

    // Second DUT, TAG_DEPTH 4, results driven by hand
    logic [N-1:0]      req_vld4;
    logic [N-1:0]      req_rdy4;
    logic              mul_arg_vld4;
    logic [FLEN-1:0]   mul_a4;
    logic [FLEN-1:0]   mul_b4;
    logic              m_vld4;
    logic [FLEN-1:0]   m_res4;
    logic [N-1:0]      res_vld4;
    logic [FLEN-1:0]   res4;
    logic              res_err4;
    logic              busy4;
    logic              perr4;

`ifdef FMUL_ARBITER_STATS_EN
    logic [N*32-1:0]   grant_cnt;
    logic [3:0]        max_occupancy;
    logic [N*32-1:0]   grant_cnt4;
    logic [2:0]        max_occupancy4;
`endif

    fmul_arbiter #(.N_REQ(N), .TAG_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
        .mul_arg_vld(mul_arg_vld), .mul_a(mul_a), .mul_b(mul_b),
        .mul_res_vld(mul_res_vld), .mul_res(mul_res), .mul_err(mul_err),
        .res_vld(res_vld), .res(res), .res_err(res_err), .busy(busy),
`ifdef FMUL_ARBITER_STATS_EN
        .grant_cnt(grant_cnt), .max_occupancy(max_occupancy),
`endif
        .proto_err(proto_err)
    );

    fmul_arbiter #(.N_REQ(N), .TAG_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_vld(req_vld4), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy4),
        .mul_arg_vld(mul_arg_vld4), .mul_a(mul_a4), .mul_b(mul_b4),
        .mul_res_vld(m_vld4), .mul_res(m_res4), .mul_err(1'b0),
        .res_vld(res_vld4), .res(res4), .res_err(res_err4), .busy(busy4),
`ifdef FMUL_ARBITER_STATS_EN
        .grant_cnt(grant_cnt4), .max_occupancy(max_occupancy4),
`endif
        .proto_err(perr4)
    );

    // Normal-operand FP32 multiply, truncating; enough for exact small values.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    logic [2:0]  p_vld;
    logic [31:0] pa0, pa1, pa2, pb0, pb1, pb2;

    always @(posedge clk) begin
        if (rst) begin
            p_vld <= '0;
        end else begin
            p_vld <= {p_vld[1:0], mul_arg_vld};
            pa0 <= mul_a;  pb0 <= mul_b;
            pa1 <= pa0;    pb1 <= pb0;
            pa2 <= pa1;    pb2 <= pb1;
        end
    end

    assign mul_res_vld = p_vld[2] | inj_vld;
    assign mul_res     = fp_mul(pa2, pb2);
    assign mul_err     = (pa2[30:23] == 8'hFF);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'(1) << i;
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*FLEN +: FLEN] = a;
        req_b[i*FLEN +: FLEN] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_vld = '0;
        req_vld4 = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        chk_res;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    logic [31:0] rr_a   [4];
    logic [31:0] rr_exp [4];
    int          drain  [4];

    initial begin
        vecs[0] = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1, 1'b0}; // 2*3=6
        vecs[1] = '{2, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1, 1'b0}; // 1.5*2=3
        vecs[2] = '{3, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b1, 1'b0}; // 1.5*1.5=2.25
        vecs[3] = '{1, 32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 1'b1, 1'b0}; // -2*0.5=-1
        vecs[4] = '{2, 32'h7F80_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1}; // inf -> err

        rr_a[0] = 32'h3F80_0000; rr_exp[0] = 32'h4000_0000;
        rr_a[1] = 32'h4000_0000; rr_exp[1] = 32'h4080_0000;
        rr_a[2] = 32'h4040_0000; rr_exp[2] = 32'h40C0_0000;
        rr_a[3] = 32'h4080_0000; rr_exp[3] = 32'h4100_0000;
        drain[0] = 1; drain[1] = 2; drain[2] = 3; drain[3] = 0;

        req_vld = '0; req_a = '0; req_b = '0; inj_vld = 1'b0;
        req_vld4 = '0; m_vld4 = 1'b0; m_res4 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        req_vld = 4'b0001;
        #1;
        chk("rst_req_rdy", req_rdy, 4'b0000);
        chk("rst_mul_arg_vld", mul_arg_vld, 1'b0);
        chk("rst_mul_a", mul_a, 32'h0);
        chk("rst_res_vld", res_vld, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_busy4", busy4, 1'b0);
        @(negedge clk);
        req_vld = '0;
        rst = 1'b0;

        // Single operations from a vector table
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            set_op(vecs[v].idx, vecs[v].a, vecs[v].b);
            req_vld = oh(vecs[v].idx);
            #1;
            chk($sformatf("vec%0d_req_rdy", v), req_rdy, oh(vecs[v].idx));
            @(negedge clk);
            req_vld = '0;
            #1;
            chk($sformatf("vec%0d_mul_arg_vld", v), mul_arg_vld, 1'b1);
            chk($sformatf("vec%0d_mul_a", v), mul_a, vecs[v].a);
            chk($sformatf("vec%0d_mul_b", v), mul_b, vecs[v].b);
            repeat (2) @(negedge clk);
            #1;
            chk($sformatf("vec%0d_res_vld_early", v), res_vld, 4'b0000);
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_res_vld", v), res_vld, oh(vecs[v].idx));
            if (vecs[v].chk_res) chk($sformatf("vec%0d_res", v), res, vecs[v].exp_res);
            chk($sformatf("vec%0d_res_err", v), res_err, vecs[v].exp_err);
        end

        // Round robin with all requesters held high for 8 cycles
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, rr_a[i], 32'h4000_0000);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_vld = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) chk($sformatf("rr_c%0d_req_rdy", c), req_rdy, oh(c % 4));
            if (c >= 4) begin
                chk($sformatf("rr_c%0d_res_vld", c), res_vld, oh((c - 4) % 4));
                chk($sformatf("rr_c%0d_res", c), res, rr_exp[(c - 4) % 4]);
            end
        end
        @(negedge clk);
        #1;
        chk("rr_idle_busy", busy, 1'b0);

        // Result strobe with nothing in flight
        @(negedge clk);
        inj_vld = 1'b1;
        #1;
        chk("perr_res_vld", res_vld, 4'b0000);
        @(negedge clk);
        inj_vld = 1'b0;
        #1;
        chk("perr_set", proto_err, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("perr_sticky", proto_err, 1'b1);

        // Reset with three operations in flight
        do_reset();
        #1;
        chk("perr_cleared", proto_err, 1'b0);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            req_vld = 4'b0111;
            #1;
            chk($sformatf("fl_c%0d_req_rdy", c), req_rdy, oh(c));
        end
        @(negedge clk);
        req_vld = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("fl_busy", busy, 1'b0);
        chk("fl_mul_arg_vld", mul_arg_vld, 1'b0);
        req_vld = 4'b1100;
        #1;
        chk("fl_ptr0_grant2", req_rdy, 4'b0100);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_vld = '0;
            #1;
            chk($sformatf("fl_k%0d_res_vld", k), res_vld, (k == 4) ? 4'b0100 : 4'b0000);
        end
        chk("fl_no_perr", proto_err, 1'b0);

        // Full tag FIFO on the TAG_DEPTH=4 instance
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_vld4 = 4'b1111;
            #1;
            chk($sformatf("full_c%0d_req_rdy", c), req_rdy4, (c < 4) ? oh(c) : 4'b0000);
        end
        @(negedge clk);
        m_vld4 = 1'b1;
        m_res4 = 32'h1234_5678;
        #1;
        chk("full_pop_res_vld", res_vld4, 4'b0001);
        chk("full_pop_res", res4, 32'h1234_5678);
        chk("full_pop_req_rdy", req_rdy4, 4'b0000);
        @(negedge clk);
        m_vld4 = 1'b0;
        #1;
        chk("full_resume_req_rdy", req_rdy4, 4'b0001);
        @(negedge clk);
        req_vld4 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m_vld4 = 1'b1;
            #1;
            chk($sformatf("full_drain%0d_res_vld", k), res_vld4, oh(drain[k]));
        end
        @(negedge clk);
        m_vld4 = 1'b0;
        #1;
        chk("full_drained_busy", busy4, 1'b0);
        chk("full_no_perr", perr4, 1'b0);

`ifdef FMUL_ARBITER_STATS_EN
        do_reset();
        #1;
        chk("stats_rst_cnt1", grant_cnt[32 +: 32], 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_vld = 4'b0010;
        end
        @(negedge clk);
        req_vld = '0;
        #1;
        chk("stats_cnt1", grant_cnt[32 +: 32], 32'd10);
        chk("stats_cnt0", grant_cnt[0 +: 32], 32'd0);
        chk("stats_max_occ", max_occupancy, 4'd4);
`endif

        repeat (6) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
